// File: rtl/mig_app_pkg.sv
// Shared constants for the MIG application-port arbiter:
// app_cmd codes, FSM state encoding and the write lane-mask helper.
package mig_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam logic [2:0] ST_WAIT_CAL = 3'd0;
    localparam logic [2:0] ST_ARB      = 3'd1;
    localparam logic [2:0] ST_CMD      = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Byte mask for a 128-bit beat: 1 = masked, so only the
    // four bytes of the addressed 32-bit lane are cleared.
    function automatic logic [15:0] lane_mask(input logic [1:0] lane);
        logic [15:0] m;
        m = 16'hFFFF;
        m[4*lane +: 4] = 4'h0;
        return m;
    endfunction

endpackage

// File: rtl/mig_app_arbiter_if.sv
// MIG application port bundle (command, write-data and read-return channels).
// master: drives app_addr/cmd/en/wdf_*, receives rdy/wdf_rdy/rd_data*; slave: the MIG side.
interface mig_app_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int APP_DW     = 128
);
    logic [ADDR_WIDTH-1:0] app_addr;
    logic [2:0]            app_cmd;
    logic                  app_en;
    logic                  app_rdy;
    logic [APP_DW-1:0]     app_wdf_data;
    logic [APP_DW/8-1:0]   app_wdf_mask;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic                  app_wdf_rdy;
    logic [APP_DW-1:0]     app_rd_data;
    logic                  app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/mig_app_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: req_i -> gnt_vld_o/gnt_idx_o; pointer advances when en_i.
// Ports: clk, rst (async high), req_i[1:0], en_i, gnt_vld_o, gnt_idx_o.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);
    logic last_q, last_d;

    always_comb begin
        gnt_vld_o = |req_i;
        // on a tie the port not granted last time wins
        gnt_idx_o = (&req_i) ? ~last_q : req_i[1];
        last_d    = last_q;
        if (en_i && gnt_vld_o) last_d = gnt_idx_o;
    end

    // reset as "port 1 last" so port 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
endmodule

// File: rtl/mig_app_arbiter.sv
// Shares one MIG app port between fetch (p0) and load/store (p1) word requesters.
// Ports: ui_clk, sys_rst, init_calib_complete, p0_*/p1_* word ports, app (mig_app_if.master).
module mig_app_arbiter
    import mig_app_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 28,
    parameter int          APP_DW      = 128,
    parameter logic [31:0] MEM_LIMIT   = 32'h1000_0000,
    parameter int          TIMEOUT_CYC = 1023
) (
    input  logic        ui_clk,
    input  logic        sys_rst,
    input  logic        init_calib_complete,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    mig_app_if.master   app
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [2:0]            state_q, state_d;
    logic                  port_q, port_d, we_q, we_d;
    logic [1:0]            lane_q, lane_d;
    logic                  en_q, en_d, wren_q, wren_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;
    logic [31:0]           rd0_q, rd0_d, rd1_q, rd1_d;
    logic [ADDR_WIDTH-1:0] aaddr_q, aaddr_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [APP_DW-1:0]     wd_q, wd_d;
    logic [APP_DW/8-1:0]   mask_q, mask_d;

    logic        gnt_vld, gnt_idx, sel_we, tmo_hit;
    logic        fin, fin_err, fin_port;
    logic [31:0] sel_addr, sel_wdata, fin_rd;
    logic        unused_addr_lsbs;

    rr_arbiter2 u_rr (
        .clk       (ui_clk),
        .rst       (sys_rst),
        .req_i     ({p1_req, p0_req}),
        .en_i      (state_q == ST_ARB && init_calib_complete),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    assign sel_we    = gnt_idx ? p1_we    : p0_we;
    assign sel_addr  = gnt_idx ? p1_addr  : p0_addr;
    assign sel_wdata = gnt_idx ? p1_wdata : p0_wdata;
    assign tmo_hit   = (tmo_q == TMO_LAST);
    assign unused_addr_lsbs = ^sel_addr[1:0];

    always_comb begin
        state_d = state_q;  port_d = port_q;  we_d = we_q;
        lane_d  = lane_q;   en_d   = en_q;    wren_d = wren_q;
        aaddr_d = aaddr_q;  cmd_d  = cmd_q;   wd_d = wd_q;
        mask_d  = mask_q;   rd0_d  = rd0_q;   rd1_d = rd1_q;
        tmo_d   = tmo_q + 1'b1;
        ack0_d = 1'b0;  ack1_d = 1'b0;
        err0_d = 1'b0;  err1_d = 1'b0;
        fin = 1'b0;  fin_err = 1'b0;  fin_port = port_q;  fin_rd = '0;

        unique case (state_q)
            ST_WAIT_CAL: if (init_calib_complete) state_d = ST_ARB;
            ST_ARB: begin
                if (!init_calib_complete) begin
                    state_d = ST_WAIT_CAL;
                end else if (gnt_vld) begin
                    port_d  = gnt_idx;
                    we_d    = sel_we;
                    lane_d  = sel_addr[3:2];
                    aaddr_d = {sel_addr[ADDR_WIDTH:4], 3'b000};
                    cmd_d   = sel_we ? CMD_WRITE : CMD_READ;
                    wd_d    = {(APP_DW/32){sel_wdata}};
                    mask_d  = lane_mask(sel_addr[3:2]);
                    if (sel_addr >= MEM_LIMIT) begin
                        fin = 1'b1;  fin_err = 1'b1;  fin_port = gnt_idx;
                    end else begin
                        state_d = ST_CMD;
                        en_d    = 1'b1;
                        wren_d  = sel_we;
                        tmo_d   = '0;
                    end
                end
            end
            ST_CMD: begin
                // command and write data retire independently
                en_d   = en_q & ~app.app_rdy;
                wren_d = wren_q & ~app.app_wdf_rdy;
                if (!we_q && en_q && app.app_rdy) begin
                    state_d = ST_RD_WAIT;
                    tmo_d   = '0;
                end else if (we_q && !en_d && !wren_d) begin
                    fin = 1'b1;
                end else if (tmo_hit) begin
                    en_d = 1'b0;  wren_d = 1'b0;
                    fin  = 1'b1;  fin_err = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (app.app_rd_data_valid) begin
                    fin    = 1'b1;
                    fin_rd = app.app_rd_data[32*lane_q +: 32];
                end else if (tmo_hit) begin
                    fin = 1'b1;  fin_err = 1'b1;
                end
            end
            ST_DONE: state_d = ST_ARB;
            default: state_d = ST_WAIT_CAL;
        endcase

        // ack/err/rdata register on the edge into DONE, so they show during DONE
        if (fin) begin
            state_d = ST_DONE;
            if (fin_port) begin
                ack1_d = 1'b1;  err1_d = fin_err;  rd1_d = fin_rd;
            end else begin
                ack0_d = 1'b1;  err0_d = fin_err;  rd0_d = fin_rd;
            end
        end
    end

    always_ff @(posedge ui_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_WAIT_CAL;
            port_q  <= 1'b0;  we_q   <= 1'b0;  lane_q <= '0;
            en_q    <= 1'b0;  wren_q <= 1'b0;  tmo_q  <= '0;
            ack0_q  <= 1'b0;  ack1_q <= 1'b0;
            err0_q  <= 1'b0;  err1_q <= 1'b0;
            rd0_q   <= '0;    rd1_q  <= '0;
            aaddr_q <= '0;    cmd_q  <= '0;
            wd_q    <= '0;    mask_q <= '1;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;  we_q   <= we_d;    lane_q <= lane_d;
            en_q    <= en_d;    wren_q <= wren_d;  tmo_q  <= tmo_d;
            ack0_q  <= ack0_d;  ack1_q <= ack1_d;
            err0_q  <= err0_d;  err1_q <= err1_d;
            rd0_q   <= rd0_d;   rd1_q  <= rd1_d;
            aaddr_q <= aaddr_d; cmd_q  <= cmd_d;
            wd_q    <= wd_d;    mask_q <= mask_d;
        end
    end

    assign p0_ack   = ack0_q;
    assign p0_err   = err0_q;
    assign p0_rdata = rd0_q;
    assign p1_ack   = ack1_q;
    assign p1_err   = err1_q;
    assign p1_rdata = rd1_q;

    assign app.app_addr     = aaddr_q;
    assign app.app_cmd      = cmd_q;
    assign app.app_en       = en_q;
    assign app.app_wdf_data = wd_q;
    assign app.app_wdf_mask = mask_q;
    assign app.app_wdf_wren = wren_q;
    assign app.app_wdf_end  = wren_q;
endmodule

// File: tb/tb_mig_app_arbiter.sv
// Bench for mig_app_arbiter: small MIG memory model, directed sequences
// and a transaction table with hand-computed results.
`timescale 1ns/1ps
module tb_mig_app_arbiter;
    import mig_app_pkg::*;

    logic ui_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic cal = 1'b0;
    logic p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic p0_ack, p1_ack, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;

    mig_app_if #(.ADDR_WIDTH(28), .APP_DW(128)) mif ();

    mig_app_arbiter #(.TIMEOUT_CYC(1023)) dut (
        .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(cal),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .app(mif)
    );

    always #5 ui_clk = ~ui_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- MIG memory model ----------------
    logic [127:0] mem [logic [27:0]];
    logic [127:0] m_wd, m_old, last_wd;
    logic [15:0]  m_wm, last_mask;
    logic         m_wv = 1'b0, m_av = 1'b0;
    logic [27:0]  m_wa, m_ra, last_aa;
    logic [2:0]   last_cmd;
    int rcnt = 0, rd_lat = 2, en_cnt = 0, end_bad = 0;
    bit rd_on = 1'b1;

    function automatic logic [127:0] mem_rd(input logic [27:0] a);
        if (mem.exists(a)) return mem[a];
        return {4{4'hA, a}};
    endfunction

    always @(posedge ui_clk) begin
        if (mif.app_en) en_cnt++;
        if (mif.app_wdf_end !== mif.app_wdf_wren) end_bad++;
        if (mif.app_wdf_wren && mif.app_wdf_rdy) begin
            m_wd = mif.app_wdf_data;  m_wm = mif.app_wdf_mask;  m_wv = 1'b1;
            last_wd = m_wd;  last_mask = m_wm;
        end
        if (mif.app_en && mif.app_rdy) begin
            last_aa = mif.app_addr;  last_cmd = mif.app_cmd;
            if (mif.app_cmd == CMD_WRITE) begin
                m_wa = mif.app_addr;  m_av = 1'b1;
            end else if (rd_on) begin
                m_ra = mif.app_addr;  rcnt = rd_lat;
            end
        end
        if (m_wv && m_av) begin
            m_old = mem_rd(m_wa);
            for (int b = 0; b < 16; b++)
                if (!m_wm[b]) m_old[8*b +: 8] = m_wd[8*b +: 8];
            mem[m_wa] = m_old;
            m_wv = 1'b0;  m_av = 1'b0;
        end
    end

    always @(negedge ui_clk) begin
        mif.app_rd_data_valid = 1'b0;
        mif.app_rd_data = '0;
        if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
                mif.app_rd_data_valid = 1'b1;
                mif.app_rd_data = mem_rd(m_ra);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_txn(input bit port, input bit we, input logic [31:0] addr, wdata,
                          output logic [31:0] rd, output logic err,
                          output int cyc, output int en_d, output int other);
        int en0;
        @(negedge ui_clk);
        en0 = en_cnt;
        if (port) begin p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1; end
        else      begin p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1; end
        cyc = 0;  other = 0;
        while (cyc < 2000) begin
            @(negedge ui_clk);
            cyc++;
            if (port ? p0_ack : p1_ack) other++;
            if (port ? p1_ack : p0_ack) break;
        end
        rd  = port ? p1_rdata : p0_rdata;
        err = port ? p1_err : p0_err;
        if (port) p1_req = 1'b0; else p0_req = 1'b0;
        en_d = en_cnt - en0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " p0_ack"}, p0_ack, 0);
        chk({tag, " p1_ack"}, p1_ack, 0);
        chk({tag, " errs"}, {p0_err, p1_err}, 0);
        chk({tag, " p0_rdata"}, p0_rdata, 0);
        chk({tag, " p1_rdata"}, p1_rdata, 0);
        chk({tag, " app_en"}, mif.app_en, 0);
        chk({tag, " wdf_wren"}, mif.app_wdf_wren, 0);
        chk({tag, " app_cmd"}, mif.app_cmd, 0);
        chk({tag, " app_addr"}, mif.app_addr, 0);
        chk({tag, " state"}, dut.state_q, ST_WAIT_CAL);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_cyc;
        int          exp_en;
        logic [27:0] exp_aa;
    } vec_t;

    vec_t tv [13];
    logic [31:0] rd;
    logic err;
    int cyc, en_d, other, acks, n, both;
    int order [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{0, 0, 32'h0000_0008, 0, 32'h1234_5678, 0, 4, 1, 28'h0};
        tv[1]  = '{1, 0, 32'h0000_000C, 0, 32'hA000_0000, 0, 4, 1, 28'h0};
        tv[2]  = '{0, 1, 32'h0000_0204, 32'hDEAD_BEEF, 0, 0, 2, 1, 28'h100};
        tv[3]  = '{1, 0, 32'h0000_0204, 0, 32'hDEAD_BEEF, 0, 4, 1, 28'h100};
        tv[4]  = '{1, 0, 32'h0000_0203, 0, 32'hA000_0100, 0, 4, 1, 28'h100};
        tv[5]  = '{0, 1, 32'h0FFF_FFFC, 32'hCAFE_F00D, 0, 0, 2, 1, 28'h7FF_FFF8};
        tv[6]  = '{0, 0, 32'h0FFF_FFF0, 0, 32'hA7FF_FFF8, 0, 4, 1, 28'h7FF_FFF8};
        tv[7]  = '{0, 0, 32'h0FFF_FFFF, 0, 32'hCAFE_F00D, 0, 4, 1, 28'h7FF_FFF8};
        tv[8]  = '{1, 0, 32'h1000_0000, 0, 32'h0, 1, 1, 0, 28'h0};
        tv[9]  = '{0, 1, 32'hFFFF_FFFC, 32'h5555_AAAA, 0, 1, 1, 0, 28'h0};
        tv[10] = '{0, 0, 32'h0000_0104, 0, 32'hA000_0080, 0, 4, 1, 28'h80};
        tv[11] = '{1, 1, 32'h0000_0008, 32'h0BAD_CAFE, 0, 0, 2, 1, 28'h0};
        tv[12] = '{1, 0, 32'h0000_0008, 0, 32'h0BAD_CAFE, 0, 4, 1, 28'h0};

        mif.app_rdy = 1'b1;
        mif.app_wdf_rdy = 1'b1;

        // reset, then calibration held low for 50 cycles
        repeat (3) @(negedge ui_clk);
        chk_reset("reset");
        sys_rst = 1'b0;
        fork
            do_txn(0, 0, 32'h0000_0100, 0, rd, err, cyc, en_d, other);
            begin
                repeat (50) @(negedge ui_clk);
                chk("cal no app_en", en_cnt, 0);
                cal = 1'b1;
            end
        join
        chk("cal ack after calib", cyc > 50, 1);
        chk("cal rdata", rd, 32'hA000_0080);
        chk("cal err", err, 0);
        chk("cal app_addr", last_aa, 28'h80);
        chk("cal app_cmd", last_cmd, CMD_READ);

        // p1 write: write data accepted 3 cycles before the command
        mif.app_rdy = 1'b0;
        mif.app_wdf_rdy = 1'b0;
        fork
            do_txn(1, 1, 32'h0000_0008, 32'h1234_5678, rd, err, cyc, en_d, other);
            begin
                for (int i = 0; i < 20 && !mif.app_en; i++) @(negedge ui_clk);
                mif.app_wdf_rdy = 1'b1;
                @(negedge ui_clk);
                chk("wr wren dropped", mif.app_wdf_wren, 0);
                chk("wr app_en held", mif.app_en, 1);
                repeat (2) @(negedge ui_clk);
                mif.app_rdy = 1'b1;
            end
        join
        chk("wr ack cycles", cyc, 5);
        chk("wr err", err, 0);
        chk("wr no p0 ack", other, 0);
        chk("wr mask", last_mask, 16'hF0FF);
        chk("wr data", last_wd, {4{32'h1234_5678}});
        chk("wr app_addr", last_aa, 28'h0);
        acks = 0;
        repeat (3) begin
            @(negedge ui_clk);
            if (p0_ack || p1_ack) acks++;
        end
        chk("wr single ack", acks, 0);

        // transaction table
        foreach (tv[i]) begin
            do_txn(tv[i].port, tv[i].we, tv[i].addr, tv[i].wdata, rd, err, cyc, en_d, other);
            chk($sformatf("v%0d cycles", i), cyc, tv[i].exp_cyc);
            chk($sformatf("v%0d err", i), err, tv[i].exp_err);
            chk($sformatf("v%0d other ack", i), other, 0);
            chk($sformatf("v%0d app_en cycles", i), en_d, tv[i].exp_en);
            if (!tv[i].we)
                chk($sformatf("v%0d rdata", i), rd, tv[i].exp_rd);
            if (tv[i].exp_en != 0) begin
                chk($sformatf("v%0d app_addr", i), last_aa, tv[i].exp_aa);
                chk($sformatf("v%0d app_cmd", i), last_cmd, tv[i].we ? CMD_WRITE : CMD_READ);
            end
        end

        // read data withheld -> timeout, then a normal read
        rd_on = 1'b0;
        do_txn(1, 0, 32'h0000_0040, 0, rd, err, cyc, en_d, other);
        chk("tmo cycles", cyc, 1025);
        chk("tmo err", err, 1);
        chk("tmo rdata", rd, 0);
        rd_on = 1'b1;
        do_txn(1, 0, 32'h0000_0008, 0, rd, err, cyc, en_d, other);
        chk("post tmo cycles", cyc, 4);
        chk("post tmo err", err, 0);
        chk("post tmo rdata", rd, 32'h0BAD_CAFE);

        // reset during RD_WAIT, read beat returns afterwards
        rd_lat = 6;
        @(negedge ui_clk);
        p0_we = 1'b0;  p0_addr = 32'h0000_0100;  p0_req = 1'b1;
        repeat (3) @(negedge ui_clk);
        chk("rst in rd_wait", dut.state_q, ST_RD_WAIT);
        sys_rst = 1'b1;
        p0_req = 1'b0;
        #1;
        chk_reset("mid reset");
        @(negedge ui_clk);
        sys_rst = 1'b0;
        acks = 0;
        repeat (12) begin
            @(negedge ui_clk);
            if (p0_ack || p1_ack) acks++;
        end
        chk("stale beat no ack", acks, 0);
        chk("stale beat rdata", p0_rdata, 0);
        rd_lat = 2;

        // both ports contend continuously -> strict alternation
        @(negedge ui_clk);
        p0_we = 1'b0;  p0_addr = 32'h0000_0008;
        p1_we = 1'b0;  p1_addr = 32'h0000_0204;
        p0_req = 1'b1;  p1_req = 1'b1;
        n = 0;  both = 0;
        for (int c = 0; c < 300 && n < 6; c++) begin
            @(negedge ui_clk);
            if (p0_ack && p1_ack) both++;
            if (p0_ack) begin
                order[n] = 0;  n++;
                chk("rr p0 rdata", p0_rdata, 32'h0BAD_CAFE);
            end else if (p1_ack) begin
                order[n] = 1;  n++;
                chk("rr p1 rdata", p1_rdata, 32'hDEAD_BEEF);
            end
        end
        p0_req = 1'b0;  p1_req = 1'b0;
        chk("rr ack count", n, 6);
        chk("rr no double ack", both, 0);
        for (int k = 0; k < 6; k++)
            chk($sformatf("rr grant %0d", k), order[k], k % 2);

        chk("wdf_end tracks wren", end_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
